// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, occupancy constants and counter helper for pipe_stage_skid
package pipe_pkg;

    // EMPTY: nothing held; ONE: main entry valid; TWO: main + skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Adds inc to count, saturating at the all-ones value of a cnt_w-bit
    // counter (cnt_w must be 1..32). The caller truncates to cnt_w bits.
    function automatic logic [31:0] sat_add(input logic [31:0] count,
                                            input logic [1:0]  inc,
                                            input int unsigned cnt_w);
        logic [32:0] sum;
        logic [32:0] max;
        max = (33'd1 << cnt_w) - 33'd1;
        sum = {1'b0, count} + {31'd0, inc};
        if (sum > max) begin
            sum = max;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready channel carrying a control field and payload
// Ports (modports):
//   master - drives valid, ctrl, data; receives ready
//   slave  - receives valid, ctrl, data; drives ready
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry.sv
// rtl/pipe_stage_skid_entry.sv - one control+payload register slot with load and clear
// Ports:
//   clk, reset      - clock, synchronous active-high reset (zeroes ctrl and data)
//   load            - capture in_ctrl/in_data
//   clear           - bubble: ctrl zeroed, data zeroed only when CLEAR_DATA=1
//   in_ctrl/in_data - value to load
//   ctrl/data       - registered contents
module pipe_entry #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 96,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear) begin
            ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
                data_d = '0;
            end
        end else if (load) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl = ctrl_q;
    assign data = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with optional two-entry skid and flush
// Ports:
//   clk, reset, flush - clock, synchronous active-high reset, synchronous flush
//   in_if  (slave)    - upstream valid/ready/ctrl/data
//   out_if (master)   - downstream valid/ready/ctrl/data, always from the main entry
//   occupancy         - entries held (0..2)
//   drop_count        - saturating count of valid entries discarded by flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 96,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_skid_if.slave  in_if,
    pipe_stage_skid_if.master out_if,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);
    pipe_state_e       state_q, state_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              in_ready_w, out_valid_w, in_fire, out_fire;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic [1:0]        occ_w, drop_inc;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_in_data;

    assign out_valid_w = (state_q != EMPTY);

    if (SKID != 0) begin : g_rdy_reg
        // Decoded from the state register only: no path from out_ready.
        assign in_ready_w = (state_q != TWO) && !reset;
    end else begin : g_rdy_comb
        assign in_ready_w = (!out_valid_w || out_if.ready) && !reset;
    end

    assign in_fire  = in_if.valid && in_ready_w;
    assign out_fire = out_valid_w && out_if.ready;

    always_comb begin
        occ_w = OCC_EMPTY;
        case (state_q)
            ONE:     occ_w = OCC_ONE;
            TWO:     occ_w = OCC_TWO;
            default: occ_w = OCC_EMPTY;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        drop_inc       = 2'd0;
        drop_count_d   = drop_count_q;
        if (flush) begin
            // An entry leaving downstream this cycle is delivered, not dropped.
            state_d      = EMPTY;
            main_clear   = 1'b1;
            skid_clear   = 1'b1;
            drop_inc     = occ_w + {1'b0, in_fire} - {1'b0, out_fire};
            drop_count_d = CNT_W'(sat_add(32'(drop_count_q), drop_inc, CNT_W));
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID != 0) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign main_in_ctrl = main_from_skid ? skid_ctrl : in_if.ctrl;
    assign main_in_data = main_from_skid ? skid_data : in_if.data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
            .clk     (clk),
            .reset   (reset),
            .load    (skid_load),
            .clear   (skid_clear),
            .in_ctrl (in_if.ctrl),
            .in_data (in_if.data),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
        );
    end else begin : g_no_skid
        logic unused_skid;
        assign skid_ctrl   = '0;
        assign skid_data   = '0;
        assign unused_skid = skid_load ^ skid_clear;
    end

    assign in_if.ready  = in_ready_w;
    assign out_if.valid = out_valid_w;
    assign out_if.ctrl  = main_ctrl;
    assign out_if.data  = main_data;
    assign occupancy    = occ_w;
    assign drop_count   = drop_count_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid in three configurations
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset, flush, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [95:0] in_data;

    logic        ir  [3];
    logic        ov  [3];
    logic [7:0]  oc  [3];
    logic [95:0] od  [3];
    logic [1:0]  occ [3];
    logic [31:0] dc  [3];

    int checks   = 0;
    int failures = 0;

    // Instance 0: defaults. 1: SKID=1, CNT_W=2. 2: SKID=0, CLEAR_DATA=0, CNT_W=4.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P_SKID = (g == 2) ? 0 : 1;
        localparam int P_CLR  = (g == 2) ? 0 : 1;
        localparam int P_CNT  = (g == 0) ? 16 : ((g == 1) ? 2 : 4);
        logic [P_CNT-1:0] dcount;
        pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(96)) up_if ();
        pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(96)) dn_if ();
        assign up_if.valid = in_valid;
        assign up_if.ctrl  = in_ctrl;
        assign up_if.data  = in_data;
        assign dn_if.ready = out_ready;
        pipe_stage_skid #(.CTRL_W(8), .DATA_W(96), .SKID(P_SKID),
                          .CLEAR_DATA(P_CLR), .CNT_W(P_CNT)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .in_if      (up_if),
            .out_if     (dn_if),
            .occupancy  (occ[g]),
            .drop_count (dcount)
        );
        assign ir[g] = up_if.ready;
        assign ov[g] = dn_if.valid;
        assign oc[g] = dn_if.ctrl;
        assign od[g] = dn_if.data;
        assign dc[g] = 32'(dcount);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a bounded FIFO (capacity 2 with skid, 1 without), the last
    // presented payload, and a saturating drop tally.
    typedef struct packed {
        logic [1:0]  n;
        logic [7:0]  c0, c1;
        logic [95:0] d0, d1;
        logic [31:0] drops;
    } mdl_t;
    mdl_t m [3];

    function automatic bit skid_on(input int k);   return k != 2; endfunction
    function automatic bit keep_data(input int k); return k == 2; endfunction
    function automatic int cntw(input int k);      return (k == 0) ? 16 : ((k == 1) ? 2 : 4); endfunction

    function automatic logic exp_in_ready(input int k);
        if (reset) return 1'b0;
        if (skid_on(k)) return m[k].n < 2;
        return (m[k].n == 0) || out_ready;
    endfunction

    task automatic advance(input int k);
        mdl_t   s;
        logic   inf, outf;
        longint sum, mx;
        s = m[k];
        if (reset) begin
            s = '0;
        end else begin
            inf  = in_valid && exp_in_ready(k);
            outf = (s.n != 0) && out_ready;
            if (flush) begin
                sum = longint'(s.drops) + longint'(s.n) + (inf ? 1 : 0) - (outf ? 1 : 0);
                mx  = (longint'(1) << cntw(k)) - 1;
                s.drops = (sum > mx) ? 32'(mx) : 32'(sum);
                s.n  = 2'd0;
                s.c0 = '0;
                s.c1 = '0;
                s.d1 = '0;
                if (!keep_data(k)) s.d0 = '0;
            end else begin
                if (outf) begin
                    if (s.n == 2) begin
                        s.c0 = s.c1;
                        s.d0 = s.d1;
                    end else begin
                        s.c0 = '0;
                        if (!keep_data(k)) s.d0 = '0;
                    end
                    s.n = s.n - 2'd1;
                end
                if (inf) begin
                    if (s.n == 0) begin
                        s.c0 = in_ctrl;
                        s.d0 = in_data;
                    end else begin
                        s.c1 = in_ctrl;
                        s.d1 = in_data;
                    end
                    s.n = s.n + 2'd1;
                end
            end
        end
        m[k] = s;
    endtask

    task automatic chk(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic sample_check();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("out_valid",  k, ov[k],  m[k].n != 0);
            chk("out_ctrl",   k, oc[k],  m[k].c0);
            chk("out_data",   k, od[k],  m[k].d0);
            chk("occupancy",  k, occ[k], m[k].n);
            chk("drop_count", k, dc[k],  m[k].drops);
            chk("in_ready",   k, ir[k],  exp_in_ready(k));
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) advance(k);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample_check();
        tick();
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [95:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h0, 96'h0);
        for (int k = 0; k < 3; k++) m[k] = '0;
        @(posedge clk); #1;
        step();

        // Single transfer, then bubble.
        reset = 1'b0; out_ready = 1'b1;
        drive(1'b1, 8'hA5, 96'h1);
        step();
        drive(1'b0, 8'h0, 96'h0);
        sample_check();
        chk("tp1_valid", 0, ov[0], 1'b1);
        chk("tp1_ctrl",  0, oc[0], 8'hA5);
        chk("tp1_occ",   0, occ[0], 2'd1);
        tick();
        sample_check();
        chk("tp1_bubble_ctrl", 0, oc[0], 8'h00);
        chk("tp1_hold_data",   2, od[2], 96'h1);
        tick();

        // Ten back-to-back entries at full rate.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i + 1), 96'(i * 1000 + 7));
            sample_check();
            chk("stream_in_ready", 0, ir[0], 1'b1);
            tick();
        end
        drive(1'b0, 8'h0, 96'h0);
        step(); step();

        // Stall with A, B, C offered.
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 96'hA); step();
        drive(1'b1, 8'hB2, 96'hB); step();
        drive(1'b1, 8'hC3, 96'hC);
        sample_check();
        chk("stall_occ",   0, occ[0], 2'd2);
        chk("stall_ready", 0, ir[0],  1'b0);
        chk("stall_head",  0, oc[0],  8'hA1);
        tick();
        step();
        out_ready = 1'b1;
        step();
        sample_check();
        chk("release_b", 0, oc[0], 8'hB2);
        tick();
        drive(1'b0, 8'h0, 96'h0);
        sample_check();
        chk("release_c", 0, oc[0], 8'hC3);
        tick();
        step(); step();

        // Flushes: full skid, then one held entry plus a same-cycle accept.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 96'h11); step();
        drive(1'b1, 8'h22, 96'h22); step();
        flush = 1'b1; drive(1'b1, 8'h33, 96'h33); step();
        flush = 1'b0; drive(1'b0, 8'h0, 96'h0);
        sample_check();
        chk("flush_valid", 0, ov[0], 1'b0);
        chk("flush_ctrl",  0, oc[0], 8'h00);
        chk("flush_drops", 0, dc[0], 32'd2);
        tick();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 8'h44, 96'h44); step();
            flush = 1'b1; step();
            flush = 1'b0; drive(1'b0, 8'h0, 96'h0);
            sample_check();
            chk("flush_drops_acc", 0, dc[0], 32'(4 + 2 * r));
            chk("flush_drops_sat", 1, dc[1], 32'd3);
            tick();
        end

        // Reset in the middle of a stall.
        drive(1'b1, 8'h55, 96'h55); step(); step();
        reset = 1'b1; drive(1'b0, 8'h0, 96'h0); step();
        sample_check();
        chk("rst_valid", 0, ov[0],  1'b0);
        chk("rst_ctrl",  0, oc[0],  8'h00);
        chk("rst_data",  0, od[0],  96'h0);
        chk("rst_occ",   0, occ[0], 2'd0);
        chk("rst_drops", 0, dc[0],  32'd0);
        chk("rst_ready", 0, ir[0],  1'b0);
        tick();
        reset = 1'b0; step();

        // SKID=0: in_ready follows out_ready within the cycle while full.
        drive(1'b1, 8'h3C, 96'hD0); step();
        drive(1'b0, 8'h0, 96'h0);
        #1; chk("comb_ready_lo", 2, ir[2], 1'b0);
        out_ready = 1'b1;
        #1; chk("comb_ready_hi", 2, ir[2], 1'b1);
        out_ready = 1'b0;
        #1;
        flush = 1'b1; step();
        flush = 1'b0;
        sample_check();
        chk("flush_keep_data",  2, od[2], 96'hD0);
        chk("flush_keep_ctrl",  2, oc[2], 8'h00);
        chk("flush_clear_data", 0, od[0], 96'h0);
        tick();

        // Randomized traffic against the reference.
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 14) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), {$urandom, $urandom, $urandom});
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
